// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-port memory arbiter: fetch port, data port and
// single-port memory side, plus the busy flag.
//
// Handshake: a requester holds x_req (and its address/data fields) until it
// sees x_gnt; x_gnt and x_rvalid are one-cycle pulses. The memory side sees
// mem_req held with stable mem_addr/mem_we/mem_wdata until the cycle it raises
// mem_ready, which completes the transfer in that same cycle.
interface mem_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [79:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [63:0] dm_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic [79:0] mem_rdata;

  logic        busy;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  // Requester/memory view.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction fetch port
// and a data port. Data normally wins; a waiting fetch is forced through
// after STARVE_LIMIT consecutive data grants. One transaction in flight.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_arbiter_if.slave bus,
  output logic [1:0] dbg_state
);

  localparam int CLOG = $clog2(STARVE_LIMIT + 1);
  localparam int CW   = (CLOG < 3) ? 3 : CLOG;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_DM = 2'd1,
    SERVE_IF = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          accept_dm, accept_if, complete;
  logic [CW-1:0] starve_cnt;
  logic [63:0]   addr_q, wdata_q;
  logic          we_q;
  logic          if_gnt_q, dm_gnt_q, if_rvalid_q, dm_rvalid_q;
  logic [79:0]   if_rdata_q;
  logic [63:0]   dm_rdata_q;

  // Next-state and arbitration decision.
  always_comb begin
    state_nx  = state;
    accept_dm = 1'b0;
    accept_if = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dm_req && !(bus.if_req && starve_cnt == LIMIT)) begin
          accept_dm = 1'b1;
          state_nx  = SERVE_DM;
        end else if (bus.if_req) begin
          accept_if = 1'b1;
          state_nx  = SERVE_IF;
        end
      end
      SERVE_DM, SERVE_IF: begin
        if (bus.mem_ready) begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, request latching, starvation counter and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state       <= state_nx;
      if_gnt_q    <= accept_if;
      dm_gnt_q    <= accept_dm;
      if_rvalid_q <= complete && (state == SERVE_IF);
      dm_rvalid_q <= complete && (state == SERVE_DM);
      if (accept_dm) begin
        addr_q  <= bus.dm_addr;
        we_q    <= bus.dm_we;
        wdata_q <= bus.dm_wdata;
        if (bus.if_req && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end
      if (accept_if) begin
        addr_q     <= bus.if_addr;
        we_q       <= 1'b0;
        starve_cnt <= '0;
      end
      if (complete && state == SERVE_IF) if_rdata_q <= bus.mem_rdata;
      if (complete && state == SERVE_DM) dm_rdata_q <= bus.mem_rdata[63:0];
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.dm_gnt    = dm_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_req   = (state != IDLE);
  // A write enable left over from a finished store must not leak onto an idle bus.
  assign bus.mem_we    = we_q && (state == SERVE_DM);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transaction table, hand-written multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         tests = 0;
  int         fails = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  typedef struct {
    logic        is_if;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [79:0] mrdata;
    int          delay;
    logic [79:0] exp_rdata;
    logic        exp_we;
  } vec_t;

  vec_t tbl[5];

  logic [79:0] exp_q[$];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] mem_data(input logic [63:0] a);
    return {a[15:0] ^ 16'h5A5A, a ^ 64'hC3C3_0F0F_A5A5_1234};
  endfunction

  task automatic idle_inputs;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic reset_dut;
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One directed transaction from an idle arbiter.
  task automatic run_txn(input vec_t v);
    if (v.is_if) begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end else begin
      bus.dm_req   = 1'b1;
      bus.dm_we    = v.we;
      bus.dm_addr  = v.addr;
      bus.dm_wdata = v.wdata;
    end
    step();
    check("txn_gnt", v.is_if ? {79'b0, bus.if_gnt} : {79'b0, bus.dm_gnt}, 80'd1);
    bus.if_req   = 1'b0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = ~v.we;
    bus.dm_addr  = {$urandom, $urandom};
    bus.dm_wdata = {$urandom, $urandom};
    for (int k = 0; k <= v.delay; k++) begin
      check("txn_mem_req", {79'b0, bus.mem_req}, 80'd1);
      check("txn_mem_addr", {16'b0, bus.mem_addr}, {16'b0, v.addr});
      check("txn_mem_we", {79'b0, bus.mem_we}, {79'b0, v.exp_we});
      if (!v.is_if) check("txn_mem_wdata", {16'b0, bus.mem_wdata}, {16'b0, v.wdata});
      if (k > 0) check("txn_gnt_pulse", {78'b0, bus.if_gnt, bus.dm_gnt}, 80'd0);
      check("txn_no_early_rvalid", {78'b0, bus.if_rvalid, bus.dm_rvalid}, 80'd0);
      bus.mem_ready = (k == v.delay);
      bus.mem_rdata = v.mrdata;
      step();
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = {$urandom, $urandom, $urandom};
    check("txn_rvalid", v.is_if ? {79'b0, bus.if_rvalid} : {79'b0, bus.dm_rvalid}, 80'd1);
    check("txn_rdata", v.is_if ? bus.if_rdata : {16'b0, bus.dm_rdata}, v.exp_rdata);
    check("txn_idle", {78'b0, bus.busy, bus.mem_req}, 80'd0);
    step();
    check("txn_rvalid_pulse", {78'b0, bus.if_rvalid, bus.dm_rvalid}, 80'd0);
    check("txn_rdata_hold", v.is_if ? bus.if_rdata : {16'b0, bus.dm_rdata}, v.exp_rdata);
  endtask

  // Stimulus and checking.
  initial begin
    logic [4:0]  exp_dg, exp_dr, exp_ig, exp_ir;
    int          ng;
    logic        p_if_req, p_dm_req, p_dm_we, p_ready;
    logic [63:0] p_if_addr, p_dm_addr, p_dm_wdata;
    logic        m_busy, m_is_if, m_we;
    logic [63:0] m_addr, m_wdata;
    int          m_starve;
    logic        e_gi, e_gd, e_ri, e_rd;
    logic [79:0] got;

    tbl[0] = '{1'b1, 1'b0, 64'h0, 64'h0, 80'h30F40A00000000000000, 0,
               80'h30F40A00000000000000, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 64'h100, 64'hDEAD, 80'h0, 3, 80'h0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 64'h2000, 64'h0, 80'hAAAA_1122334455667788, 1,
               80'h0000_1122334455667788, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF6, 64'h0, 80'h0123456789ABCDEF0123, 2,
               80'h0123456789ABCDEF0123, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF,
               80'hFFFF_0000000000000005, 0, 80'h0000_0000000000000005, 1'b1};

    // Reset state, with requests held high to show nothing is accepted.
    idle_inputs();
    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_gnt", {78'b0, bus.if_gnt, bus.dm_gnt}, 80'd0);
      check("rst_ctrl", {76'b0, bus.busy, bus.mem_req, bus.mem_we, bus.if_rvalid}, 80'd0);
    end
    check("rst_dm_rvalid", {79'b0, bus.dm_rvalid}, 80'd0);
    check("rst_if_rdata", bus.if_rdata, 80'd0);
    check("rst_dm_rdata", {16'b0, bus.dm_rdata}, 80'd0);
    check("rst_mem_addr", {16'b0, bus.mem_addr}, 80'd0);
    check("rst_mem_wdata", {16'b0, bus.mem_wdata}, 80'd0);
    check("rst_state", {78'b0, dbg_state}, 80'd0);
    reset_dut();

    // Directed transaction table.
    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    // Contention: both ports always requesting, memory always ready.
    reset_dut();
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'h40;
    bus.dm_req    = 1'b1;
    bus.dm_addr   = 64'h80;
    bus.mem_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      step();
      if (bus.if_gnt || bus.dm_gnt) begin
        check("contention_order", {79'b0, bus.if_gnt}, (ng % 5 == 4) ? 80'd1 : 80'd0);
        check("contention_one_gnt", {79'b0, bus.if_gnt & bus.dm_gnt}, 80'd0);
        ng++;
      end
    end
    check("contention_grants", 80'(ng), 80'd10);

    // Simultaneous single requests.
    reset_dut();
    exp_dg = 5'b00001;
    exp_dr = 5'b00010;
    exp_ig = 5'b00100;
    exp_ir = 5'b01000;
    bus.if_req    = 1'b1;
    bus.if_addr   = 64'h8;
    bus.dm_req    = 1'b1;
    bus.dm_addr   = 64'h10;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("simul_dm_gnt", {79'b0, bus.dm_gnt}, {79'b0, exp_dg[c]});
      check("simul_dm_rvalid", {79'b0, bus.dm_rvalid}, {79'b0, exp_dr[c]});
      check("simul_if_gnt", {79'b0, bus.if_gnt}, {79'b0, exp_ig[c]});
      check("simul_if_rvalid", {79'b0, bus.if_rvalid}, {79'b0, exp_ir[c]});
      if (bus.dm_gnt) bus.dm_req = 1'b0;
      if (bus.if_gnt) bus.if_req = 1'b0;
    end

    // Reset in the cycle after dm_gnt, late mem_ready one cycle later.
    reset_dut();
    bus.dm_req  = 1'b1;
    bus.dm_addr = 64'h40;
    step();
    check("rstmid_gnt", {79'b0, bus.dm_gnt}, 80'd1);
    bus.dm_req = 1'b0;
    step();
    rst_n = 1'b0;
    bus.dm_req = 1'b1;
    step();
    check("rstmid_no_gnt", {79'b0, bus.dm_gnt}, 80'd0);
    check("rstmid_busy", {78'b0, bus.busy, bus.mem_req}, 80'd0);
    rst_n = 1'b1;
    bus.dm_req = 1'b0;
    bus.mem_ready = 1'b1;
    step();
    check("rstmid_no_rvalid", {79'b0, bus.dm_rvalid}, 80'd0);
    check("rstmid_idle", {77'b0, bus.busy, bus.mem_req, bus.dm_gnt}, 80'd0);
    bus.mem_ready = 1'b0;
    step();
    check("rstmid_no_rvalid2", {79'b0, bus.dm_rvalid}, 80'd0);
    run_txn(tbl[2]);

    // Randomized run against the transaction-level reference model.
    reset_dut();
    p_if_req = 1'b0; p_dm_req = 1'b0; p_dm_we = 1'b0; p_ready = 1'b0;
    p_if_addr = '0; p_dm_addr = '0; p_dm_wdata = '0;
    m_busy = 1'b0; m_is_if = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    m_starve = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      e_gi = 1'b0; e_gd = 1'b0; e_ri = 1'b0; e_rd = 1'b0;
      if (!m_busy) begin
        if (p_dm_req && !(p_if_req && m_starve == LIMIT)) begin
          e_gd = 1'b1; m_busy = 1'b1; m_is_if = 1'b0;
          m_addr = p_dm_addr; m_we = p_dm_we; m_wdata = p_dm_wdata;
          if (p_if_req && m_starve < LIMIT) m_starve++;
        end else if (p_if_req) begin
          e_gi = 1'b1; m_busy = 1'b1; m_is_if = 1'b1;
          m_addr = p_if_addr; m_we = 1'b0; m_starve = 0;
        end
      end else if (p_ready) begin
        if (m_is_if) e_ri = 1'b1; else e_rd = 1'b1;
        exp_q.push_back(mem_data(m_addr));
        m_busy = 1'b0;
      end
      check("rnd_gnt", {78'b0, bus.if_gnt, bus.dm_gnt}, {78'b0, e_gi, e_gd});
      check("rnd_rvalid", {78'b0, bus.if_rvalid, bus.dm_rvalid}, {78'b0, e_ri, e_rd});
      check("rnd_busy", {78'b0, bus.busy, bus.mem_req}, {78'b0, m_busy, m_busy});
      if (m_busy) begin
        check("rnd_mem_addr", {16'b0, bus.mem_addr}, {16'b0, m_addr});
        check("rnd_mem_we", {79'b0, bus.mem_we}, {79'b0, m_we});
        if (m_we) check("rnd_mem_wdata", {16'b0, bus.mem_wdata}, {16'b0, m_wdata});
      end
      if (e_ri || e_rd) begin
        got = e_ri ? bus.if_rdata : {16'b0, bus.dm_rdata};
        check("rnd_rdata", got, e_ri ? exp_q[0] : {16'b0, exp_q[0][63:0]});
        void'(exp_q.pop_front());
      end
      // Requesters react to grants; memory returns address-derived data.
      if (bus.if_gnt) bus.if_req = 1'b0;
      if (bus.dm_gnt) bus.dm_req = 1'b0;
      if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = {$urandom, $urandom};
      end
      if (!bus.dm_req) begin
        bus.dm_we    = 1'($urandom_range(0, 1));
        bus.dm_addr  = {$urandom, $urandom};
        bus.dm_wdata = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 0) bus.dm_req = 1'b1;
      end
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = mem_data(bus.mem_addr);
      p_if_req = bus.if_req; p_if_addr = bus.if_addr;
      p_dm_req = bus.dm_req; p_dm_we = bus.dm_we;
      p_dm_addr = bus.dm_addr; p_dm_wdata = bus.dm_wdata;
      p_ready = bus.mem_ready;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
